// File: rtl/game_pkg.sv
// Shared encodings and helpers for the game controller.
package game_pkg;

  // Codes the play screen decodes directly.
  typedef enum logic [2:0] {
    StTitle = 3'b000,
    StPlay  = 3'b010,
    StWin   = 3'b100,
    StLose  = 3'b110
  } state_t;

  localparam logic [1:0] DirNone  = 2'b00;
  localparam logic [1:0] DirLeft  = 2'b01;
  localparam logic [1:0] DirRight = 2'b10;

  // Digit 0..9 to active-low {g,f,e,d,c,b,a}; anything else blanks.
  function automatic logic [6:0] seg7_decode(input logic [3:0] digit);
    logic [6:0] seg;
    seg = 7'h7F;
    unique case (digit)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/game_ctrl_if.sv
// Buttons, play-screen link and display lines of the game controller.
interface game_ctrl_if;
  logic       btn_start;
  logic       btn_left;
  logic       btn_right;
  logic [3:0] score;
  logic [3:0] miss;
  logic [2:0] state;
  logic [1:0] dir;
  logic [3:0] an;
  logic [7:0] seg;

  // Board / play-screen side.
  modport master (
    output btn_start, btn_left, btn_right, score, miss,
    input  state, dir, an, seg
  );

  // Controller side.
  modport slave (
    input  btn_start, btn_left, btn_right, score, miss,
    output state, dir, an, seg
  );
endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a counting debouncer with rising-edge pulse.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic rise
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      sync_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;
  logic            rise_q, rise_d;

  // Count consecutive cycles of disagreement; flip once the run is long enough.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CntLast) begin
        level_d = sync_q[1];
        rise_d  = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Synchronizer and debouncer state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q  <= 2'b00;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/game_ctrl.sv
// Game front end: button conditioning, game FSM, result latch and 4-digit display scan.
module game_ctrl
  import game_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned SCAN_CYCLES     = 100_000,
  parameter logic [3:0]  WIN_SCORE       = 4'd9,
  parameter logic [3:0]  LOSE_MISS       = 4'd3
) (
  input logic        clk,
  input logic        rst,
  game_ctrl_if.slave bus
);

  localparam int unsigned ScanW = $clog2(SCAN_CYCLES + 1);
  localparam logic [ScanW-1:0] ScanLast = ScanW'(SCAN_CYCLES - 1);

  logic start_level, start_pulse;
  logic left_level, left_rise;
  logic right_level, right_rise;

  state_t          state_q, state_d;
  logic [3:0]      score_lat_q, score_lat_d;
  logic [3:0]      miss_lat_q, miss_lat_d;
  logic [1:0]      dir_q, dir_d;
  logic [ScanW-1:0] scan_cnt_q;
  logic [1:0]      scan_idx_q;
  logic [3:0]      an_q;
  logic [7:0]      seg_q;
  logic [3:0]      disp_score, disp_miss, digit;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
    .clk   (clk),
    .rst   (rst),
    .btn   (bus.btn_start),
    .level (start_level),
    .rise  (start_pulse)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
    .clk   (clk),
    .rst   (rst),
    .btn   (bus.btn_left),
    .level (left_level),
    .rise  (left_rise)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
    .clk   (clk),
    .rst   (rst),
    .btn   (bus.btn_right),
    .level (right_level),
    .rise  (right_rise)
  );

  // Next state, result latch and direction; loss takes priority over win.
  always_comb begin
    state_d     = state_q;
    score_lat_d = score_lat_q;
    miss_lat_d  = miss_lat_q;
    dir_d       = DirNone;
    unique case (state_q)
      StTitle: begin
        if (start_pulse) begin
          state_d     = StPlay;
          score_lat_d = 4'd0;
          miss_lat_d  = 4'd0;
        end
      end
      StPlay: begin
        if (bus.miss >= LOSE_MISS) begin
          state_d = StLose;
        end else if (bus.score >= WIN_SCORE) begin
          state_d = StWin;
        end
        if (state_d != StPlay) begin
          score_lat_d = bus.score;
          miss_lat_d  = bus.miss;
        end
      end
      StWin, StLose: begin
        if (start_pulse) state_d = StTitle;
      end
      default: state_d = StTitle;
    endcase
    // Gate on the next state so dir is never non-zero alongside a non-PLAY code.
    if (state_d == StPlay) begin
      unique case ({right_level, left_level})
        2'b01:   dir_d = DirLeft;
        2'b10:   dir_d = DirRight;
        default: dir_d = DirNone;
      endcase
    end
  end

  // FSM, result latch and direction registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StTitle;
      score_lat_q <= 4'd0;
      miss_lat_q  <= 4'd0;
      dir_q       <= DirNone;
    end else begin
      state_q     <= state_d;
      score_lat_q <= score_lat_d;
      miss_lat_q  <= miss_lat_d;
      dir_q       <= dir_d;
    end
  end

  // Pick the digit for the current scan position from live or latched counts.
  always_comb begin
    disp_score = (state_q == StPlay) ? bus.score : score_lat_q;
    disp_miss  = (state_q == StPlay) ? bus.miss  : miss_lat_q;
    digit      = 4'd0;
    unique case (scan_idx_q)
      2'd0: digit = disp_score % 4'd10;
      2'd1: digit = disp_score / 4'd10;
      2'd2: digit = disp_miss % 4'd10;
      2'd3: digit = disp_miss / 4'd10;
      default: digit = 4'd0;
    endcase
  end

  // Scan timer and registered digit drive; an/seg trail the index by one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt_q <= '0;
      scan_idx_q <= 2'd0;
      an_q       <= 4'b1111;
      seg_q      <= 8'hFF;
    end else begin
      if (scan_cnt_q == ScanLast) begin
        scan_cnt_q <= '0;
        scan_idx_q <= scan_idx_q + 2'd1;
      end else begin
        scan_cnt_q <= scan_cnt_q + 1'b1;
      end
      an_q  <= ~(4'b0001 << scan_idx_q);
      seg_q <= {1'b1, seg7_decode(digit)};
    end
  end

  assign bus.state = state_q;
  assign bus.dir   = dir_q;
  assign bus.an    = an_q;
  assign bus.seg   = seg_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed self-checking bench for game_ctrl (DEBOUNCE_CYCLES=8, SCAN_CYCLES=4).
module tb_game_ctrl;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  game_ctrl_if bus ();

  game_ctrl #(
    .DEBOUNCE_CYCLES (8),
    .SCAN_CYCLES     (4),
    .WIN_SCORE       (4'd9),
    .LOSE_MISS       (4'd3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Wait up to max_cyc sampling edges for the state code, then compare.
  task automatic wait_state(input string tag, input logic [2:0] exp, input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (bus.state == exp) break;
    end
    check_eq(tag, 32'(bus.state), 32'(exp));
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Align to the start of digit 0, then check one full rotation (4 cycles per digit).
  task automatic check_scan(input string tag, input logic [7:0] s0, input logic [7:0] s1,
                            input logic [7:0] s2, input logic [7:0] s3);
    logic [3:0] prev_an;
    logic [3:0] an_exp [4];
    logic [7:0] seg_exp [4];
    logic       found;
    an_exp[0] = 4'b1110; an_exp[1] = 4'b1101; an_exp[2] = 4'b1011; an_exp[3] = 4'b0111;
    seg_exp[0] = s0; seg_exp[1] = s1; seg_exp[2] = s2; seg_exp[3] = s3;
    found = 1'b0;
    prev_an = bus.an;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (bus.an == 4'b1110 && prev_an == 4'b0111) begin
        found = 1'b1;
        break;
      end
      prev_an = bus.an;
    end
    check_eq({tag, "_align"}, 32'(found), 32'd1);
    for (int i = 0; i < 16; i++) begin
      if (i != 0) @(negedge clk);
      check_eq($sformatf("%s_an%0d", tag, i), 32'(bus.an), 32'(an_exp[i/4]));
      check_eq($sformatf("%s_seg%0d", tag, i), 32'(bus.seg), 32'(seg_exp[i/4]));
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    bus.btn_start = 1'b0;
    bus.btn_left  = 1'b0;
    bus.btn_right = 1'b0;
    bus.score     = 4'd0;
    bus.miss      = 4'd0;
    rst = 1'b1;
    #1 rst = 1'b0;
    idle(3);
    check_eq("rst_state", 32'(bus.state), 32'h0);
    check_eq("rst_dir", 32'(bus.dir), 32'h0);
    check_eq("rst_an", 32'(bus.an), 32'hF);
    check_eq("rst_seg", 32'(bus.seg), 32'hFF);
    rst = 1'b1;
    idle(1);
    check_eq("first_an", 32'(bus.an), 32'hE);

    // Short glitch on start must be rejected.
    bus.btn_start = 1'b1;
    idle(5);
    bus.btn_start = 1'b0;
    idle(15);
    check_eq("glitch_state", 32'(bus.state), 32'h0);

    // Held start: PLAY within 2+8+2 cycles, and no re-trigger while held.
    bus.btn_start = 1'b1;
    wait_state("start_play", 3'b010, 12);
    idle(20);
    check_eq("held_start", 32'(bus.state), 32'h2);
    bus.btn_start = 1'b0;
    idle(12);

    // Direction from accepted levels.
    bus.btn_left = 1'b1;
    idle(12);
    check_eq("dir_left", 32'(bus.dir), 32'h1);
    bus.btn_right = 1'b1;
    idle(12);
    check_eq("dir_both", 32'(bus.dir), 32'h0);
    bus.btn_left = 1'b0;
    idle(12);
    check_eq("dir_right", 32'(bus.dir), 32'h2);
    bus.btn_right = 1'b0;
    idle(12);
    check_eq("dir_none", 32'(bus.dir), 32'h0);

    // Win on score=9, result latched in the threshold cycle.
    bus.score = 4'd9;
    bus.miss  = 4'd1;
    idle(1);
    check_eq("win_state", 32'(bus.state), 32'h4);
    bus.score = 4'd0;
    bus.miss  = 4'd0;
    check_scan("win_disp", 8'h90, 8'hC0, 8'hF9, 8'hC0);

    // WIN -> TITLE, buttons ignored for dir in TITLE, then back to PLAY.
    bus.btn_start = 1'b1;
    wait_state("win_title", 3'b000, 12);
    bus.btn_start = 1'b0;
    idle(12);
    bus.btn_left = 1'b1;
    idle(12);
    check_eq("title_dir", 32'(bus.dir), 32'h0);
    bus.btn_left = 1'b0;
    idle(12);
    bus.btn_start = 1'b1;
    wait_state("title_play", 3'b010, 12);
    check_eq("lat_score_clr", 32'(dut.score_lat_q), 32'h0);
    check_eq("lat_miss_clr", 32'(dut.miss_lat_q), 32'h0);
    bus.btn_start = 1'b0;
    idle(12);

    // Win and lose in the same cycle: loss wins.
    bus.score = 4'd12;
    bus.miss  = 4'd3;
    idle(1);
    check_eq("lose_state", 32'(bus.state), 32'h6);
    check_scan("lose_disp", 8'hA4, 8'hF9, 8'hB0, 8'hC0);

    // Back into PLAY, hold left, then asynchronous reset.
    bus.score = 4'd0;
    bus.miss  = 4'd0;
    bus.btn_start = 1'b1;
    wait_state("lose_title", 3'b000, 12);
    bus.btn_start = 1'b0;
    idle(12);
    bus.btn_start = 1'b1;
    wait_state("replay", 3'b010, 12);
    bus.btn_start = 1'b0;
    bus.btn_left  = 1'b1;
    idle(12);
    check_eq("pre_rst_dir", 32'(bus.dir), 32'h1);
    #2 rst = 1'b0;
    #1;
    check_eq("async_state", 32'(bus.state), 32'h0);
    check_eq("async_dir", 32'(bus.dir), 32'h0);
    check_eq("async_an", 32'(bus.an), 32'hF);
    idle(2);
    rst = 1'b1;
    bus.btn_left = 1'b0;
    idle(2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
